// File: rtl/graph_pkg.sv
// Shared sizing and tag type for the graph memory read-port arbiter.
package graph_pkg;

    localparam int unsigned PROC_BITS  = 4;
    localparam int unsigned NUM_PROC   = 1 << PROC_BITS;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MEM_LAT    = 2;
    localparam int unsigned TAG_ADDR_W = ADDR_W + PROC_BITS;

    typedef struct packed {
        logic                 v;
        logic [PROC_BITS-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/graph_mem_arbiter_if.sv
// Requester, memory-port and response signals of one arbitrated read port.
interface graph_mem_arbiter_if;
    import graph_pkg::*;

    logic [NUM_PROC-1:0]             req_valid_in;
    logic [NUM_PROC-1:0][ADDR_W-1:0] req_addr_in;
    logic [NUM_PROC-1:0]             req_ready_out;
    logic [TAG_ADDR_W-1:0]           mem_addr_out;
    logic                            mem_valid_out;
    logic [DATA_W-1:0]               mem_data_in;
    logic                            resp_valid_out;
    logic [PROC_BITS-1:0]            resp_proc_out;
    logic [DATA_W-1:0]               resp_data_out;

    modport slave (
        input  req_valid_in, req_addr_in, mem_data_in,
        output req_ready_out, mem_addr_out, mem_valid_out,
        output resp_valid_out, resp_proc_out, resp_data_out
    );

    modport master (
        output req_valid_in, req_addr_in, mem_data_in,
        input  req_ready_out, mem_addr_out, mem_valid_out,
        input  resp_valid_out, resp_proc_out, resp_data_out
    );

endinterface

// File: rtl/graph_mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin select; first requester at or after ptr, wrapping.
module graph_mem_arbiter_rr_pick
    import graph_pkg::*;
(
    input  logic [NUM_PROC-1:0]  req,
    input  logic [PROC_BITS-1:0] ptr,
    output logic [NUM_PROC-1:0]  gnt,
    output logic [PROC_BITS-1:0] idx,
    output logic                 any_gnt
);

    logic [PROC_BITS-1:0] cand;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        any_gnt = 1'b0;
        cand    = '0;
        // NUM_PROC is a power of two, so the PROC_BITS-wide sum wraps for free
        for (int unsigned i = 0; i < NUM_PROC; i++) begin
            cand = ptr + PROC_BITS'(i);
            if (!any_gnt && req[cand]) begin
                any_gnt = 1'b1;
                idx     = cand;
            end
        end
        gnt[idx] = any_gnt;
    end

endmodule

// File: rtl/graph_mem_arbiter.sv
// Round-robin arbiter for one fixed-latency graph_memory read port.
// Define GRAPH_ARB_STATS_EN to add per-requester saturating grant counters.
module graph_mem_arbiter
    import graph_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  arb_en_in,
    graph_mem_arbiter_if.slave    bus,
    output logic                  idle_out,
    input  logic [PROC_BITS-1:0]  stat_sel_in,
    output logic [15:0]           stat_cnt_out
);

    logic [NUM_PROC-1:0]   req_act;
    logic [NUM_PROC-1:0]   gnt;
    logic [PROC_BITS-1:0]  win_idx;
    logic                  hs;
    logic [PROC_BITS-1:0]  rr_ptr_q;
    logic                  mem_valid_q;
    logic [TAG_ADDR_W-1:0] mem_addr_q;
    rd_tag_t [MEM_LAT-1:0] tag_q;
    logic                  in_flight;

    assign req_act = bus.req_valid_in & {NUM_PROC{arb_en_in}};

    graph_mem_arbiter_rr_pick u_rr_pick (
        .req     (req_act),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .idx     (win_idx),
        .any_gnt (hs)
    );

    assign bus.req_ready_out = gnt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rr_ptr_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            tag_q       <= '0;
        end else begin
            mem_valid_q <= hs;
            if (hs) begin
                rr_ptr_q   <= win_idx + PROC_BITS'(1);
                mem_addr_q <= {win_idx, bus.req_addr_in[win_idx]};
            end
            // Tag enters as the strobe leaves, so the last stage lines up with read data
            tag_q[0].v  <= mem_valid_q;
            tag_q[0].id <= mem_addr_q[TAG_ADDR_W-1 -: PROC_BITS];
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign bus.mem_valid_out  = mem_valid_q;
    assign bus.mem_addr_out   = mem_addr_q;
    assign bus.resp_valid_out = tag_q[MEM_LAT-1].v;
    assign bus.resp_proc_out  = tag_q[MEM_LAT-1].v ? tag_q[MEM_LAT-1].id : '0;
    assign bus.resp_data_out  = tag_q[MEM_LAT-1].v ? bus.mem_data_in : '0;

    // A read in its response cycle is already delivered, so the last stage is not counted
    always_comb begin
        in_flight = mem_valid_q;
        for (int unsigned i = 0; i + 1 < MEM_LAT; i++) begin
            in_flight = in_flight | tag_q[i].v;
        end
    end

    assign idle_out = !in_flight;

`ifdef GRAPH_ARB_STATS_EN
    logic [NUM_PROC-1:0][15:0] stat_cnt_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            stat_cnt_q <= '0;
        end else if (hs && (stat_cnt_q[win_idx] != 16'hFFFF)) begin
            stat_cnt_q[win_idx] <= stat_cnt_q[win_idx] + 16'd1;
        end
    end

    assign stat_cnt_out = stat_cnt_q[stat_sel_in];
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel_in;
    assign stat_cnt_out    = '0;
`endif

endmodule

// File: tb/tb_graph_mem_arbiter.sv
// Randomized and directed bench for graph_mem_arbiter against a cycle-level reference model.
module tb_graph_mem_arbiter;
    import graph_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 arb_en = 1'b0;
    logic [PROC_BITS-1:0] stat_sel = '0;
    logic [15:0]          stat_cnt;
    logic                 idle;

    graph_mem_arbiter_if bus ();

    graph_mem_arbiter dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .arb_en_in    (arb_en),
        .bus          (bus),
        .idle_out     (idle),
        .stat_sel_in  (stat_sel),
        .stat_cnt_out (stat_cnt)
    );

    always #5 clk = ~clk;

    logic              req_v [NUM_PROC];
    logic [ADDR_W-1:0] req_a [NUM_PROC];

    always_comb begin
        for (int i = 0; i < NUM_PROC; i++) begin
            bus.req_valid_in[i] = req_v[i];
            bus.req_addr_in[i]  = req_a[i];
        end
    end

    // Memory contents: one preloaded word, everything else a hash of the tagged address
    function automatic logic [DATA_W-1:0] mem_fn(input logic [TAG_ADDR_W-1:0] a);
        if (a == 36'h3_0000_0010) return 32'h0000_CAFE;
        return (a[DATA_W-1:0] * 32'h9E37_79B1) ^ {28'h0, a[TAG_ADDR_W-1 -: 4]};
    endfunction

    logic [DATA_W-1:0] md1, md2;
    always @(posedge clk) begin
        md1 <= mem_fn(bus.mem_addr_out);
        md2 <= md1;
    end
    assign bus.mem_data_in = md2;

    // Reference model state
    int                    ptr_m;
    bit                    exp_mv;
    logic [TAG_ADDR_W-1:0] exp_ma;
    bit                    rv [8];
    int                    rp [8];
    logic [DATA_W-1:0]     rd [8];
    int unsigned           gcnt [NUM_PROC];
    int                    cyc;
    int                    last_win;
    int                    resp_seen;
    int                    n_checks;
    int                    n_err;

    logic [NUM_PROC-1:0]   obs_ready;
    logic [TAG_ADDR_W-1:0] obs_ma;
    logic [DATA_W-1:0]     obs_resp_d;
    logic                  obs_idle;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        ptr_m  = 0;
        exp_mv = 1'b0;
        exp_ma = '0;
        for (int i = 0; i < 8; i++) rv[i] = 1'b0;
        for (int i = 0; i < NUM_PROC; i++) gcnt[i] = 0;
    endtask

    // One clock cycle: check all outputs at the falling edge, then advance the model
    task automatic step();
        int                  win;
        int                  s;
        logic [NUM_PROC-1:0] exp_gnt;
        bit                  exp_idle;
        @(negedge clk);
        win = -1;
        if (arb_en) begin
            for (int i = 0; i < NUM_PROC; i++) begin
                if (win < 0 && req_v[(ptr_m + i) % NUM_PROC]) win = (ptr_m + i) % NUM_PROC;
            end
        end
        exp_gnt = '0;
        if (win >= 0) exp_gnt[win] = 1'b1;
        check_eq("req_ready", bus.req_ready_out, exp_gnt);
        check_eq("mem_valid", bus.mem_valid_out, exp_mv);
        check_eq("mem_addr", bus.mem_addr_out, exp_ma);
        s = cyc % 8;
        check_eq("resp_valid", bus.resp_valid_out, rv[s]);
        if (rv[s]) begin
            check_eq("resp_proc", bus.resp_proc_out, rp[s]);
            check_eq("resp_data", bus.resp_data_out, rd[s]);
            resp_seen++;
        end
        exp_idle = 1'b1;
        for (int d = 1; d <= MEM_LAT; d++) if (rv[(cyc + d) % 8]) exp_idle = 1'b0;
        check_eq("idle", idle, exp_idle);
`ifdef GRAPH_ARB_STATS_EN
        check_eq("stat_cnt", stat_cnt, gcnt[stat_sel]);
`else
        check_eq("stat_cnt", stat_cnt, 0);
`endif
        obs_ready  = bus.req_ready_out;
        obs_ma     = bus.mem_addr_out;
        obs_resp_d = bus.resp_data_out;
        obs_idle   = idle;
        rv[s]  = 1'b0;
        exp_mv = (win >= 0);
        if (win >= 0) begin
            exp_ma = {PROC_BITS'(win), req_a[win]};
            ptr_m  = (win + 1) % NUM_PROC;
            s      = (cyc + 1 + MEM_LAT) % 8;
            rv[s]  = 1'b1;
            rp[s]  = win;
            rd[s]  = mem_fn(exp_ma);
            if (gcnt[win] < 65535) gcnt[win]++;
        end
        last_win = win;
        cyc++;
        @(posedge clk);
        #1;
        if (win >= 0) req_v[win] = 1'b0;
    endtask

    // Called just after a rising edge; outputs must clear as soon as reset asserts
    task automatic reset_mid();
        for (int i = 0; i < NUM_PROC; i++) req_v[i] = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("rst_ready", bus.req_ready_out, 0);
        check_eq("rst_mem_valid", bus.mem_valid_out, 0);
        check_eq("rst_mem_addr", bus.mem_addr_out, 0);
        check_eq("rst_resp_valid", bus.resp_valid_out, 0);
        check_eq("rst_resp_proc", bus.resp_proc_out, 0);
        check_eq("rst_resp_data", bus.resp_data_out, 0);
        check_eq("rst_idle", idle, 1);
        check_eq("rst_stat", stat_cnt, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    int exp3 [6];

    initial begin
        n_checks  = 0;
        n_err     = 0;
        cyc       = 0;
        resp_seen = 0;
        exp3      = '{0, 5, 9, 0, 5, 9};
        for (int i = 0; i < NUM_PROC; i++) begin
            req_v[i] = 1'b0;
            req_a[i] = '0;
        end
        model_clear();
        @(posedge clk);
        #1;
        reset_mid();
        arb_en = 1'b1;

        // Single read from proc 3 at 0x10
        req_a[3] = 32'h10;
        req_v[3] = 1'b1;
        step();
        check_eq("t2_grant", obs_ready, 16'h0008);
        step();
        check_eq("t2_mem_addr", obs_ma, 36'h3_0000_0010);
        step();
        step();
        check_eq("t2_resp_data", obs_resp_d, 32'h0000_CAFE);

        // Procs 0, 5, 9 requesting continuously from pointer 0
        reset_mid();
        arb_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_v[0] = 1'b1;
            req_v[5] = 1'b1;
            req_v[9] = 1'b1;
            req_a[0] = $urandom;
            req_a[5] = $urandom;
            req_a[9] = $urandom;
            step();
            check_eq("t3_order", last_win, exp3[k]);
        end
        req_v[0] = 1'b0;
        req_v[5] = 1'b0;
        req_v[9] = 1'b0;
        repeat (4) step();

        // Wrap from 15 to 0; proc 2 withdraws before it is reached
        req_v[14] = 1'b1;
        step();
        req_v[15] = 1'b1;
        req_v[0]  = 1'b1;
        req_v[2]  = 1'b1;
        step();
        check_eq("t4_wrap_15", obs_ready, 16'h8000);
        step();
        check_eq("t4_wrap_0", obs_ready, 16'h0001);
        req_v[2] = 1'b0;
        step();
        check_eq("t4_dropped", obs_ready, 16'h0000);
        repeat (3) step();

        // Drain with two reads in flight
        req_v[1] = 1'b1;
        req_v[4] = 1'b1;
        resp_seen = 0;
        step();
        step();
        arb_en   = 1'b0;
        req_v[6] = 1'b1;
        step();
        step();
        check_eq("t5_busy", obs_idle, 0);
        step();
        check_eq("t5_idle", obs_idle, 1);
        check_eq("t5_resp_count", resp_seen, 2);
        req_v[6] = 1'b0;
        step();

        // Random traffic with a reset in the middle
        for (int c = 0; c < 600; c++) begin
            arb_en = ($urandom % 10) != 0;
            for (int i = 0; i < NUM_PROC; i++) begin
                if (!req_v[i]) begin
                    if ($urandom % 4 == 0) begin
                        req_v[i] = 1'b1;
                        req_a[i] = $urandom;
                    end
                end else if ($urandom % 20 == 0) begin
                    req_v[i] = 1'b0;
                end
            end
            stat_sel = PROC_BITS'($urandom);
            if (c == 300) reset_mid();
            else step();
        end
        arb_en = 1'b1;
        for (int i = 0; i < NUM_PROC; i++) req_v[i] = 1'b0;
        repeat (4) step();

        // Grant counters
        reset_mid();
        arb_en   = 1'b1;
        stat_sel = 4'd7;
        for (int k = 0; k < 5; k++) begin
            req_v[7] = 1'b1;
            step();
        end
        step();
`ifdef GRAPH_ARB_STATS_EN
        check_eq("t6_count5", stat_cnt, 16'd5);
        for (int k = 0; k < 65535; k++) begin
            req_v[7] = 1'b1;
            step();
        end
        step();
        check_eq("t6_saturate", stat_cnt, 16'hFFFF);
`else
        check_eq("t6_no_stats", stat_cnt, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
